apb_timer: RTL
==============

Name: apb_timer

Overview:
- APB completer peripheral that sits directly downstream of the AHB-to-APB bridge and occupies one of its PSEL slots.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt to the interrupt controller.
- Drives PREADY/PRDATA back into the bridge's per-peripheral ready/data mux.

Parameters:
- XLEN, 32, APB data width (32 or 64); registers are 32 bits, held in PRDATA[31:0], with upper bits read as 0.
- PRESCALE_BITS, 16, width of the prescaler divider register.

Ports:
- PCLK  in  1  APB clock (same as bridge HCLK)
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  completer select from bridge
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  8  byte address within the 256 B window; PADDR[1:0] is ignored
- PWDATA  in  XLEN  write data
- PSTRB  in  XLEN/8  byte strobes; only [3:0] are used
- PREADY  out  1  access complete
- PRDATA  out  XLEN  read data
- TimerIntr  out  1  interrupt, level high

Behaviour:
- Reset is asynchronous on PRESETn low. All registers clear to 0; PRDATA is 0; TimerIntr is 0. PREADY is 1 when the optional feature is off; with it on, PREADY is 0.
- Register map (word offsets):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IE; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_BITS-1:0].
  - 0x08 COUNT: 32 bits.
  - 0x0C COMPARE: 32 bits.
  - 0x10 STATUS: bit0 MATCH; write 1 to clear.
  - Other offsets read 0 and ignore writes.
- Access commit: an access commits when PSEL & PENABLE & PREADY.
  - Writes update registers at the rising edge ending the committing cycle, byte-masked by PSTRB[3:0].
  - PRDATA is combinational from PADDR whenever PSEL=1, else 0. Read has no side effects.
- Prescaler: an internal counter pcnt runs while EN=1.
  - tick=1 when pcnt==PRESCALE; pcnt then returns to 0, otherwise it increments.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - EN=0 holds pcnt at 0, so there is no tick.
  - Any write to PRESCALE clears pcnt.
- Counter, on a tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTORELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping 0xFFFFFFFF to 0 with no flag.
- Simultaneous events:
  - A write to COUNT wins over a tick increment in the same cycle.
  - A MATCH set wins over a W1C clear in the same cycle.
  - A write to COMPARE takes effect from the next cycle's comparison.
- TimerIntr = MATCH & IE, registered (one cycle after MATCH/IE change).
- Reset asserted mid-access: all state clears immediately. The bridge is reset by the same PRESETn, so no protocol recovery is required.
- PSEL with PENABLE=0 (setup phase) causes no state change.

Optional Feature:
- Macro: APBTIMER_WAITSTATE_EN.
- Defined: every access inserts exactly one wait state.
  - A registered flag sets on the first access-phase cycle (PSEL & PENABLE & ~wait_done).
  - PREADY=0 in that first access cycle and 1 in the second; the commit happens in the second.
  - The flag clears on commit or when PSEL drops.
  - PREADY resets to 0.
- Undefined: PREADY is constantly 1, giving zero-wait access.

Test Plan:
- Reset, then read all five offsets plus 0x14 -> all return 0; TimerIntr=0; PREADY=1 (with macro: 0 in the first access cycle).
- Write PRESCALE=3, COMPARE=5, CTRL=0x7 (EN, AUTORELOAD, IE) -> COUNT increments every 4 cycles. MATCH sets on the tick where COUNT==5 and COUNT goes to 0; TimerIntr goes high one cycle later.
- Write COUNT=0xFFFFFFFE, COMPARE=0x10, PRESCALE=0, CTRL=0x1 -> COUNT reads 0xFFFFFFFF then 0x00000000 on consecutive cycles; MATCH stays 0.
- Write COUNT=0x000000AA with PSTRB=0x1 over COUNT=0x12345678 -> reads 0x123456AA. A write in the same cycle as a tick -> the written value is read back, not value+1.
- MATCH=1; write STATUS=0x1 in the same cycle a new match occurs -> MATCH stays 1. A later W1C with no match -> MATCH=0 and TimerIntr falls a cycle later.
- With APBTIMER_WAITSTATE_EN: back-to-back write then read through the bridge -> each access shows PREADY low for exactly one PENABLE cycle, and the read returns the written data.

Source files
------------

// File: rtl/apb_timer.sv
// APB completer timer: prescaled 32-bit up-counter, compare match flag and level interrupt.
// Define APBTIMER_WAITSTATE_EN to make every APB access take exactly one wait state.
module apb_timer #(
   parameter int XLEN          = 32,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [7:0]          PADDR,
   input  logic [XLEN-1:0]     PWDATA,
   input  logic [XLEN/8-1:0]   PSTRB,
   output logic                PREADY,
   output logic [XLEN-1:0]     PRDATA,
   output logic                TimerIntr
);

   localparam logic [5:0] ADDR_CTRL     = 6'h00;
   localparam logic [5:0] ADDR_PRESCALE = 6'h01;
   localparam logic [5:0] ADDR_COUNT    = 6'h02;
   localparam logic [5:0] ADDR_COMPARE  = 6'h03;
   localparam logic [5:0] ADDR_STATUS   = 6'h04;

   logic [2:0]               ctrl;
   logic [PRESCALE_BITS-1:0] prescale;
   logic [PRESCALE_BITS-1:0] pcnt;
   logic [31:0]              count;
   logic [31:0]              compare;
   logic                     match;

   logic [5:0]  word;
   logic [31:0] wdata;
   logic [3:0]  strb;
   logic        commit;
   logic        wr_commit;
   logic        wr_ctrl;
   logic        wr_prescale;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        en;
   logic        autoreload;
   logic        ie;
   logic        tick;
   logic        hit;
   logic [31:0] ctrl_ext;
   logic [31:0] prescale_ext;
   logic [31:0] ctrl_merged;
   logic [31:0] prescale_merged;
   logic [31:0] count_merged;
   logic [31:0] compare_merged;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   assign word      = PADDR[7:2];
   assign wdata     = PWDATA[31:0];
   assign strb      = PSTRB[3:0];
   assign commit    = PSEL & PENABLE & PREADY;
   assign wr_commit = commit & PWRITE;

   assign wr_ctrl     = wr_commit & (word == ADDR_CTRL);
   assign wr_prescale = wr_commit & (word == ADDR_PRESCALE);
   assign wr_count    = wr_commit & (word == ADDR_COUNT);
   assign wr_compare  = wr_commit & (word == ADDR_COMPARE);
   assign wr_status   = wr_commit & (word == ADDR_STATUS);

   assign en         = ctrl[0];
   assign autoreload = ctrl[1];
   assign ie         = ctrl[2];

   always_comb begin
      ctrl_ext                              = '0;
      ctrl_ext[2:0]                         = ctrl;
      prescale_ext                          = '0;
      prescale_ext[PRESCALE_BITS-1:0]       = prescale;
   end

   assign ctrl_merged     = merge_bytes(ctrl_ext, wdata, strb);
   assign prescale_merged = merge_bytes(prescale_ext, wdata, strb);
   assign count_merged    = merge_bytes(count, wdata, strb);
   assign compare_merged  = merge_bytes(compare, wdata, strb);

   assign tick = en & (pcnt == prescale);
   assign hit  = tick & (count == compare);

`ifdef APBTIMER_WAITSTATE_EN
   // Flag marks that the first access-phase cycle has been spent; PREADY follows it.
   logic wait_done;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_done <= 1'b0;
      else if (!PSEL || commit)
         wait_done <= 1'b0;
      else if (PENABLE)
         wait_done <= 1'b1;
   end

   assign PREADY = wait_done;
`else
   assign PREADY = 1'b1;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl     <= '0;
         prescale <= '0;
         compare  <= '0;
      end else begin
         if (wr_ctrl)     ctrl     <= ctrl_merged[2:0];
         if (wr_prescale) prescale <= prescale_merged[PRESCALE_BITS-1:0];
         if (wr_compare)  compare  <= compare_merged;
      end
   end

   // Any PRESCALE write restarts the divider so the new period starts cleanly.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         pcnt <= '0;
      else if (!en || wr_prescale || tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + PRESCALE_BITS'(1);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         count <= '0;
      else if (wr_count)
         count <= count_merged;
      else if (hit && autoreload)
         count <= '0;
      else if (tick)
         count <= count + 32'd1;
   end

   // A new match outranks a write-1-to-clear landing in the same cycle.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         match <= 1'b0;
      else if (hit)
         match <= 1'b1;
      else if (wr_status && strb[0] && wdata[0])
         match <= 1'b0;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         TimerIntr <= 1'b0;
      else
         TimerIntr <= match & ie;
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL) begin
         case (word)
            ADDR_CTRL:     PRDATA[31:0] = ctrl_ext;
            ADDR_PRESCALE: PRDATA[31:0] = prescale_ext;
            ADDR_COUNT:    PRDATA[31:0] = count;
            ADDR_COMPARE:  PRDATA[31:0] = compare;
            ADDR_STATUS:   PRDATA[31:0] = {31'd0, match};
            default:       PRDATA[31:0] = 32'd0;
         endcase
      end
   end

   assign unused_bits = ^{PADDR[1:0], PWDATA, PSTRB, ctrl_merged, prescale_merged};

endmodule
